// File: rtl/wb_regfile_if.sv
// Bus between the MEM/WB pipeline register, the ID-stage read ports and the writeback register file.
// Signal names keep the register file's point of view (_i into it, _o out of it).
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              RegWrite_i;
  logic              MemtoReg_i;
  logic [DATA_W-1:0] MemData_i;
  logic [DATA_W-1:0] RegData_i;
  logic [ADDR_W-1:0] RegAddr_i;
  logic [ADDR_W-1:0] RSaddr_i;
  logic [ADDR_W-1:0] RTaddr_i;
  logic [DATA_W-1:0] RSdata_o;
  logic [DATA_W-1:0] RTdata_o;
  logic [DATA_W-1:0] WBdata_o;
  logic [CNT_W-1:0]  WBcount_o;

  modport master (
    output RegWrite_i, MemtoReg_i, MemData_i, RegData_i, RegAddr_i, RSaddr_i, RTaddr_i,
    input  RSdata_o, RTdata_o, WBdata_o, WBcount_o
  );

  modport slave (
    input  RegWrite_i, MemtoReg_i, MemData_i, RegData_i, RegAddr_i, RSaddr_i, RTaddr_i,
    output RSdata_o, RTdata_o, WBdata_o, WBcount_o
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, writes the general-purpose register file,
// serves two bypassed combinational read ports and counts retired register writes.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input logic         clk_i,
  input logic         rst_i,
  wb_regfile_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [DATA_W-1:0] wb_data;
  logic              we;

  // Index 0 is hardwired to zero; the bypass lets ID see the value retiring this cycle.
  function automatic logic [DATA_W-1:0] rd_sel(
    input logic [ADDR_W-1:0] idx,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data,
    input logic [DATA_W-1:0] stored
  );
    if (idx == '0)                    return '0;
    else if (wr_en && idx == wr_addr) return wr_data;
    else                              return stored;
  endfunction

  assign wb_data = bus.MemtoReg_i ? bus.MemData_i : bus.RegData_i;
  assign we      = bus.RegWrite_i && (bus.RegAddr_i != '0);
  assign cnt_d   = cnt_q + 1'b1;

  assign bus.WBdata_o  = wb_data;
  assign bus.WBcount_o = cnt_q;
  assign bus.RSdata_o  = rd_sel(bus.RSaddr_i, we, bus.RegAddr_i, wb_data, regs_q[bus.RSaddr_i]);
  assign bus.RTdata_o  = rd_sel(bus.RTaddr_i, we, bus.RegAddr_i, wb_data, regs_q[bus.RTaddr_i]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      cnt_q <= '0;
    end else if (we) begin
      regs_q[bus.RegAddr_i] <= wb_data;
      cnt_q                 <= cnt_d;
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Randomized and directed bench for wb_regfile against an array-based register file model.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus  ();
  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus4)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mdl [32];
  int unsigned mcnt;

  function automatic logic [31:0] exp_wb();
    return bus.MemtoReg_i ? bus.MemData_i : bus.RegData_i;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.RegWrite_i && bus.RegAddr_i != 5'd0 && idx == bus.RegAddr_i) return exp_wb();
    return mdl[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mcnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst && bus.RegWrite_i && bus.RegAddr_i != 5'd0) begin
      mdl[bus.RegAddr_i] = exp_wb();
      mcnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.RSaddr_i = 5'(i);
      bus.RTaddr_i = 5'(31 - i);
      #1;
      n_cmp++;
      if (bus.RSdata_o !== 32'd0) begin
        n_err++;
        $display("FAIL reset_rs idx=%0d got=%h want=0", i, bus.RSdata_o);
      end
      n_cmp++;
      if (bus.RTdata_o !== 32'd0) begin
        n_err++;
        $display("FAIL reset_rt idx=%0d got=%h want=0", 31 - i, bus.RTdata_o);
      end
    end
    n_cmp++;
    if (bus.WBcount_o !== 16'd0) begin
      n_err++;
      $display("FAIL reset_count got=%0d want=0", bus.WBcount_o);
    end
    n_cmp++;
    if (bus4.WBcount_o !== 4'd0) begin
      n_err++;
      $display("FAIL reset_count4 got=%0d want=0", bus4.WBcount_o);
    end
  endtask

  task automatic test_alu_write();
    @(negedge clk);
    bus.RegWrite_i = 1'b1;
    bus.MemtoReg_i = 1'b0;
    bus.RegData_i  = 32'h0000_1234;
    bus.MemData_i  = 32'h5555_0000;
    bus.RegAddr_i  = 5'd5;
    #1;
    n_cmp++;
    if (bus.WBdata_o !== 32'h0000_1234) begin
      n_err++;
      $display("FAIL alu_wbdata got=%h want=00001234", bus.WBdata_o);
    end
    tick();
    bus.RegWrite_i = 1'b0;
    bus.RSaddr_i   = 5'd5;
    #1;
    n_cmp++;
    if (bus.RSdata_o !== 32'h0000_1234) begin
      n_err++;
      $display("FAIL alu_readback got=%h want=00001234", bus.RSdata_o);
    end
    n_cmp++;
    if (bus.WBcount_o !== 16'd1) begin
      n_err++;
      $display("FAIL alu_count got=%0d want=1", bus.WBcount_o);
    end
  endtask

  task automatic test_mem_bypass();
    @(negedge clk);
    bus.RegWrite_i = 1'b1;
    bus.MemtoReg_i = 1'b1;
    bus.MemData_i  = 32'hDEAD_BEEF;
    bus.RegData_i  = 32'h0000_0001;
    bus.RegAddr_i  = 5'd9;
    bus.RSaddr_i   = 5'd9;
    bus.RTaddr_i   = 5'd9;
    #1;
    n_cmp++;
    if (bus.RSdata_o !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL bypass_rs got=%h want=deadbeef", bus.RSdata_o);
    end
    n_cmp++;
    if (bus.RTdata_o !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL bypass_rt got=%h want=deadbeef", bus.RTdata_o);
    end
    tick();
    bus.RegWrite_i = 1'b0;
    bus.MemData_i  = 32'h0;
    #1;
    n_cmp++;
    if (bus.RSdata_o !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL stored_rs got=%h want=deadbeef", bus.RSdata_o);
    end
    n_cmp++;
    if (bus.RTdata_o !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL stored_rt got=%h want=deadbeef", bus.RTdata_o);
    end
    n_cmp++;
    if (bus.WBcount_o !== 16'd2) begin
      n_err++;
      $display("FAIL bypass_count got=%0d want=2", bus.WBcount_o);
    end
  endtask

  task automatic test_zero_reg();
    logic [15:0] cnt_before;
    @(negedge clk);
    cnt_before     = 16'(mcnt);
    bus.RegWrite_i = 1'b1;
    bus.MemtoReg_i = 1'b0;
    bus.RegData_i  = 32'hFFFF_FFFF;
    bus.RegAddr_i  = 5'd0;
    bus.RSaddr_i   = 5'd0;
    bus.RTaddr_i   = 5'd0;
    #1;
    n_cmp++;
    if (bus.RSdata_o !== 32'd0) begin
      n_err++;
      $display("FAIL zero_pre got=%h want=0", bus.RSdata_o);
    end
    tick();
    n_cmp++;
    if (bus.RTdata_o !== 32'd0) begin
      n_err++;
      $display("FAIL zero_post got=%h want=0", bus.RTdata_o);
    end
    n_cmp++;
    if (bus.WBcount_o !== cnt_before) begin
      n_err++;
      $display("FAIL zero_count got=%0d want=%0d", bus.WBcount_o, cnt_before);
    end
    bus.RegWrite_i = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.RegWrite_i = 1'b1;
    bus.MemtoReg_i = 1'b0;
    bus.RegData_i  = 32'hA5A5_A5A5;
    bus.RegAddr_i  = 5'd3;
    tick();
    bus.RegWrite_i = 1'b0;
    bus.RSaddr_i   = 5'd3;
    #1;
    n_cmp++;
    if (bus.RSdata_o !== 32'hA5A5_A5A5) begin
      n_err++;
      $display("FAIL areset_pre got=%h want=a5a5a5a5", bus.RSdata_o);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (bus.RSdata_o !== 32'd0) begin
      n_err++;
      $display("FAIL areset_immediate got=%h want=0", bus.RSdata_o);
    end
    n_cmp++;
    if (bus.WBcount_o !== 16'd0) begin
      n_err++;
      $display("FAIL areset_count got=%0d want=0", bus.WBcount_o);
    end
    bus.RegWrite_i = 1'b1;
    bus.RegData_i  = 32'h0000_0055;
    #1;
    n_cmp++;
    if (bus.RSdata_o !== 32'h0000_0055) begin
      n_err++;
      $display("FAIL areset_bypass got=%h want=00000055", bus.RSdata_o);
    end
    tick();
    bus.RegWrite_i = 1'b0;
    #1;
    n_cmp++;
    if (bus.RSdata_o !== 32'd0 || bus.WBcount_o !== 16'd0) begin
      n_err++;
      $display("FAIL areset_write_lost got=%h/%0d want=0/0", bus.RSdata_o, bus.WBcount_o);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.RegWrite_i = 1'b1;
    bus.RegData_i  = 32'h0000_0007;
    tick();
    bus.RegWrite_i = 1'b0;
    #1;
    n_cmp++;
    if (bus.RSdata_o !== 32'h0000_0007) begin
      n_err++;
      $display("FAIL areset_release got=%h want=00000007", bus.RSdata_o);
    end
    n_cmp++;
    if (bus.WBcount_o !== 16'd1) begin
      n_err++;
      $display("FAIL areset_release_count got=%0d want=1", bus.WBcount_o);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      bus.RegWrite_i = ($urandom_range(0, 3) != 0);
      bus.MemtoReg_i = 1'($urandom_range(0, 1));
      bus.MemData_i  = $urandom;
      bus.RegData_i  = $urandom;
      bus.RegAddr_i  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      bus.RSaddr_i   = ($urandom_range(0, 2) == 0) ? bus.RegAddr_i : 5'($urandom_range(0, 31));
      bus.RTaddr_i   = ($urandom_range(0, 3) == 0) ? bus.RSaddr_i  : 5'($urandom_range(0, 31));
      #1;
      n_cmp++;
      if (bus.WBdata_o !== exp_wb()) begin
        n_err++;
        $display("FAIL rand_wbdata it=%0d got=%h want=%h", n, bus.WBdata_o, exp_wb());
      end
      n_cmp++;
      if (bus.RSdata_o !== exp_rd(bus.RSaddr_i)) begin
        n_err++;
        $display("FAIL rand_rs it=%0d idx=%0d got=%h want=%h", n, bus.RSaddr_i, bus.RSdata_o, exp_rd(bus.RSaddr_i));
      end
      n_cmp++;
      if (bus.RTdata_o !== exp_rd(bus.RTaddr_i)) begin
        n_err++;
        $display("FAIL rand_rt it=%0d idx=%0d got=%h want=%h", n, bus.RTaddr_i, bus.RTdata_o, exp_rd(bus.RTaddr_i));
      end
      tick();
      n_cmp++;
      if (bus.WBcount_o !== 16'(mcnt)) begin
        n_err++;
        $display("FAIL rand_count it=%0d got=%0d want=%0d", n, bus.WBcount_o, mcnt);
      end
    end
    bus.RegWrite_i = 1'b0;
  endtask

  task automatic test_counter_wrap();
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      bus4.RegWrite_i = 1'b1;
      bus4.RegData_i  = 32'(i);
      bus4.RegAddr_i  = 5'd1;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus4.RegWrite_i = 1'b0;
    bus4.RSaddr_i   = 5'd1;
    #1;
    n_cmp++;
    if (bus4.WBcount_o !== 4'd1) begin
      n_err++;
      $display("FAIL wrap_count got=%0d want=1", bus4.WBcount_o);
    end
    n_cmp++;
    if (bus4.RSdata_o !== 32'd17) begin
      n_err++;
      $display("FAIL wrap_data got=%h want=00000011", bus4.RSdata_o);
    end
    for (int i = 0; i < 3; i++) begin
      bus4.RegAddr_i = 5'($urandom_range(1, 31));
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus4.WBcount_o !== 4'd1) begin
        n_err++;
        $display("FAIL idle_count cyc=%0d got=%0d want=1", i, bus4.WBcount_o);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached without completion");
    $fatal(1);
  end

  initial begin
    rst            = 1'b0;
    bus.RegWrite_i = 1'b0;
    bus.MemtoReg_i = 1'b0;
    bus.MemData_i  = '0;
    bus.RegData_i  = '0;
    bus.RegAddr_i  = '0;
    bus.RSaddr_i   = '0;
    bus.RTaddr_i   = '0;
    bus4.RegWrite_i = 1'b0;
    bus4.MemtoReg_i = 1'b0;
    bus4.MemData_i  = '0;
    bus4.RegData_i  = '0;
    bus4.RegAddr_i  = '0;
    bus4.RSaddr_i   = '0;
    bus4.RTaddr_i   = '0;
    model_reset();

    test_reset();
    test_alu_write();
    test_mem_bypass();
    test_zero_reg();
    test_async_reset();
    test_random();
    test_counter_wrap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
